// File: rtl/pcie_ats_inv_responder.sv
// rtl/pcie_ats_inv_responder.sv - ATS invalidate request snooper and completion generator
module pcie_ats_inv_responder #(
  parameter int         AXIS_DATA_WIDTH  = 512,
  parameter int         AXIS_TUSER_WIDTH = 228,
  parameter int         FIFO_DEPTH       = 8,
  parameter bit         BLOCK_ON_FULL    = 1'b1,
  parameter logic [7:0] INV_REQ_CODE     = 8'h01,
  parameter logic [7:0] INV_CPL_CODE     = 8'h02
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  input  logic [AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  output logic                            s_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  output logic [AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
  input  logic                            m_axis_tready,
  output logic [AXIS_DATA_WIDTH-1:0]      rq_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]    rq_axis_tkeep,
  output logic                            rq_axis_tvalid,
  output logic                            rq_axis_tlast,
  input  logic                            rq_axis_tready,
  output logic [31:0]                     inv_req_count,
  output logic [31:0]                     inv_cpl_count,
  output logic [31:0]                     inv_drop_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            ats_hit,
  output logic [7:0]                      ats_tag
);

  localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int EW     = 29;  // {req_id[15:0], tag[7:0], itag[4:0]}

  typedef enum logic {ST_IDLE, ST_SEND} state_t;
  state_t state_q, state_d;

  logic             sop;
  logic [3:0]       req_type;
  logic [15:0]      req_id;
  logic [7:0]       tag;
  logic [7:0]       msg_code;
  logic [4:0]       itag;
  logic             inv_hdr;
  logic             stall;
  logic             beat_acc;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             drop;
  logic             pop;
  logic             cpl_done;
  logic [LW-1:0]    wr_ptr;
  logic [LW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]    head;
  logic [AXIS_DATA_WIDTH-1:0] cpl_beat;
  logic [AXIS_DATA_WIDTH-1:0] rq_data;
  logic [KEEP_W-1:0]          rq_keep;

  assign req_type = s_axis_tdata[78:75];
  assign req_id   = s_axis_tdata[95:80];
  assign tag      = s_axis_tdata[103:96];
  assign msg_code = s_axis_tdata[111:104];
  assign itag     = s_axis_tdata[132:128];

  // Occupancy is evaluated before this cycle's pop, so a full FIFO never takes a push-through.
  assign level      = wr_ptr - rd_ptr;
  assign fifo_full  = (level == LW'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);

  assign inv_hdr  = s_axis_tvalid & sop & (req_type == 4'b1110) & (msg_code == INV_REQ_CODE);
  assign stall    = BLOCK_ON_FULL & inv_hdr & fifo_full;
  assign beat_acc = s_axis_tvalid & s_axis_tready;
  assign push     = beat_acc & inv_hdr & ~fifo_full;
  assign drop     = beat_acc & inv_hdr & fifo_full;
  assign head     = fifo_mem[rd_ptr[AW-1:0]];

  assign s_axis_tready = m_axis_tready & ~stall;
  assign m_axis_tvalid = s_axis_tvalid & ~stall;
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tuser  = s_axis_tuser;

  assign rq_axis_tvalid = (state_q == ST_SEND);
  assign rq_axis_tlast  = (state_q == ST_SEND);
  assign rq_axis_tdata  = rq_data;
  assign rq_axis_tkeep  = rq_keep;
  assign fifo_level     = level;

  // Track start-of-packet so only the first beat of a TLP is decoded as a header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sop <= 1'b1;
    end else if (beat_acc) begin
      sop <= s_axis_tlast;
    end
  end

  // Pending-request storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= {req_id, tag, itag};
    end
  end

  // FIFO pointers; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Completion state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // IDLE pops one request into the RQ register; SEND holds it until the RQ handshake.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    cpl_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (rq_axis_tready) begin
          cpl_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Build the single-beat Invalidate Completion from the FIFO head entry.
  always_comb begin
    cpl_beat            = '0;
    cpl_beat[74:64]     = 11'd1;
    cpl_beat[78:75]     = 4'b1110;
    cpl_beat[95:80]     = head[28:13];
    cpl_beat[103:96]    = head[12:5];
    cpl_beat[111:104]   = INV_CPL_CODE;
    cpl_beat[114:112]   = 3'b010;
    cpl_beat[159:128]   = 32'h1 << head[4:0];
    cpl_beat[191:160]   = 32'h1;
  end

  // RQ output register, loaded on pop and held stable throughout SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_data <= '0;
      rq_keep <= '0;
    end else if (pop) begin
      rq_data <= cpl_beat;
      rq_keep <= {{(KEEP_W-24){1'b0}}, 24'hFF_FFFF};
    end
  end

  // Statistics counters; they wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_req_count  <= '0;
      inv_cpl_count  <= '0;
      inv_drop_count <= '0;
    end else begin
      if (push)     inv_req_count  <= inv_req_count + 32'd1;
      if (cpl_done) inv_cpl_count  <= inv_cpl_count + 32'd1;
      if (drop)     inv_drop_count <= inv_drop_count + 32'd1;
    end
  end

  // Hit pulse and tag of the most recently accepted invalidate request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ats_hit <= 1'b0;
      ats_tag <= '0;
    end else begin
      ats_hit <= push;
      if (push) ats_tag <= tag;
    end
  end

endmodule
